// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with a valid/ready handshake and a 2-entry skid buffer, so in_ready is registered.
// Flush inserts a NOP bubble. Optional stall/bubble counters are built when IF_ID_PERF_EN is defined.
module if_id_pipe_reg #(
    parameter int                  IR_SIZE  = 16,
    parameter int                  PC_SIZE  = 32,
    parameter logic [IR_SIZE-1:0]  NOP_WORD = '0,
    parameter logic [PC_SIZE-1:0]  RESET_PC = 32,
    parameter int                  CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IR_SIZE-1:0] in_ir,
    input  logic [PC_SIZE-1:0] in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IR_SIZE-1:0] out_ir,
    output logic [PC_SIZE-1:0] out_pc
`ifdef IF_ID_PERF_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
`endif
);

    logic               main_valid_q, main_valid_d;
    logic [IR_SIZE-1:0] main_ir_q, main_ir_d;
    logic [PC_SIZE-1:0] main_pc_q, main_pc_d;
    logic               skid_valid_q, skid_valid_d;
    logic [IR_SIZE-1:0] skid_ir_q, skid_ir_d;
    logic [PC_SIZE-1:0] skid_pc_q, skid_pc_d;
    logic               in_ready_q, in_ready_d;
    logic               accept, pop;

    assign accept = in_valid && in_ready_q;
    assign pop    = main_valid_q && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_ir_d    = main_ir_q;
        main_pc_d    = main_pc_q;
        skid_valid_d = skid_valid_q;
        skid_ir_d    = skid_ir_q;
        skid_pc_d    = skid_pc_q;
        if (flush) begin
            // main_pc keeps its value so the redirect point stays visible
            main_valid_d = 1'b0;
            main_ir_d    = NOP_WORD;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept) begin
                main_valid_d = 1'b1;
                main_ir_d    = in_ir;
                main_pc_d    = in_pc;
            end
        end else if (pop) begin
            if (skid_valid_q) begin
                main_ir_d    = skid_ir_q;
                main_pc_d    = skid_pc_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_ir_d    = in_ir;
                main_pc_d    = in_pc;
            end else begin
                main_valid_d = 1'b0;
                main_ir_d    = NOP_WORD;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_ir_d    = in_ir;
            skid_pc_d    = in_pc;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            main_ir_q    <= NOP_WORD;
            main_pc_q    <= RESET_PC;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_ir_q    <= main_ir_d;
            main_pc_q    <= main_pc_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Skid payload is only meaningful while skid_valid is set, so it needs no reset
    always_ff @(posedge clk) begin
        skid_ir_q <= skid_ir_d;
        skid_pc_q <= skid_pc_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_ir    = main_ir_q;
    assign out_pc    = main_pc_q;

`ifdef IF_ID_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q + {{(CNT_W-1){1'b0}}, (main_valid_q && !out_ready)};
        bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, !main_valid_q};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/if_id_pipe_reg.md
# if_id_pipe_reg

Parametrised fetch/decode pipeline register for the five-stage processor. It carries the instruction word and its PC from fetch to decode. Compared with the earlier single-register IF/ID latch, it adds a valid/ready handshake, a 2-entry skid buffer so `in_ready` is registered, a flush that inserts a NOP bubble, and optional performance counters.

## Interface

Parameters:
- `IR_SIZE`, 16: instruction word width.
- `PC_SIZE`, 32: PC width.
- `NOP_WORD`, 0: encoding driven on `out_ir` whenever the stage holds no valid instruction.
- `RESET_PC`, 32 (2**5): `out_pc` value after reset.
- `CNT_W`, 16: perf counter width. Used only with `IF_ID_PERF_EN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage can accept; registered, equals `!skid_valid`.
- `in_ir`  in  IR_SIZE  fetched instruction.
- `in_pc`  in  PC_SIZE  PC of the fetched instruction.
- `flush`  in  1  discard all held and incoming instructions (branch/jump redirect).
- `out_valid`  out  1  `out_ir`/`out_pc` hold a valid instruction (main slot valid).
- `out_ready`  in  1  decode consumes the instruction this cycle.
- `out_ir`  out  IR_SIZE  main slot instruction.
- `out_pc`  out  PC_SIZE  main slot PC.
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`. Present only with `IF_ID_PERF_EN`.
- `bubble_cnt`  out  CNT_W  cycles with `!out_valid`. Present only with `IF_ID_PERF_EN`.

## Operation

- Storage: a main slot (`main_valid`, `main_ir`, `main_pc`) drives the outputs. A skid slot (`skid_valid`, `skid_ir`, `skid_pc`) is internal.
- Events: accept = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- Priority per edge: reset > flush > normal transfer.
- Reset (`reset`=0 at the edge): `main_valid`=0, `skid_valid`=0, `main_ir`=NOP_WORD, `main_pc`=RESET_PC. Skid data is don't-care. Counters are cleared to 0.
- Flush: both valid bits are cleared and `main_ir`=NOP_WORD. `main_pc` holds its value.
  - An instruction accepted in the same cycle is discarded. Upstream still treats it as consumed.
  - A pop in the same cycle completes normally for decode.
- Normal transfer, by state:
  - Main empty, accept: the input loads main.
  - Main full, pop, skid empty, accept: the input loads main.
  - Main full, pop, skid empty, no accept: `main_valid`=0 and `main_ir`=NOP_WORD.
  - Main full, pop, skid full: skid moves to main and skid empties. `in_ready` was 0, so no accept can occur.
  - Main full, no pop, accept: the input loads skid and `in_ready` falls next cycle.
  - Main full, no pop, no accept: hold.
- Ordering: strict FIFO. An instruction is never duplicated or dropped, except by flush.
- Invariant: `skid_valid` implies `main_valid`.
- Held data is stable while `out_valid && !out_ready`.

## Timing

- Latency: an instruction accepted at edge N appears at `out_*` after edge N with `out_valid`=1. This is 1 cycle input-to-output.
- Throughput: 1 instruction per cycle while `out_ready`=1.
- `in_ready` is a pure register output with no combinational path from `out_ready`.
- All outputs are registered.
- Output values directly after reset: `out_valid`=0, `in_ready`=1, `out_ir`=NOP_WORD, `out_pc`=RESET_PC, counters 0.
- Reset asserted mid-operation takes effect at the next edge and overrides flush and any transfer.
- After a flush edge: `out_valid`=0 and `in_ready`=1. A new accept is possible in the next cycle.
- Counters wrap modulo 2**CNT_W. They are sampled on outputs at the edge and are not cleared by flush.

## Configuration

- `IF_ID_PERF_EN` defined:
  - `stall_cnt` and `bubble_cnt` ports and counters exist.
  - Each increments by 1 at every edge where its condition held during the preceding cycle and reset is inactive.
- `IF_ID_PERF_EN` undefined:
  - The ports and counters are absent.
  - Datapath behaviour is identical.

## Test plan

- Reset: hold `reset`=0 for 2 cycles with `in_valid`=1, `flush`=1 -> `out_valid`=0, `in_ready`=1, `out_ir`=0x0000, `out_pc`=32, counters 0.
- Streaming: `out_ready`=1, feed ir 0x1111/0x2222/0x3333 at pc 40/41/42 back-to-back -> each appears 1 cycle later in order, no gaps, `in_ready` stays 1.
- Backpressure: `out_ready`=0, feed 0xA001, 0xA002 -> `out_ir`=0xA001, then `in_ready`=0 after the second accept, and 0xA003 is not taken.
  - Then `out_ready`=1 -> outputs 0xA002, then 0xA003.
  - `stall_cnt` equals the number of held cycles.
- Flush with skid full: main=0xB001, skid=0xB002, assert `flush` -> next cycle `out_valid`=0, `out_ir`=0x0000, `out_pc` unchanged, `in_ready`=1.
  - The next input 0xC000 appears alone.
- Flush coincident with accept and pop: main=0xD001 popped, 0xD002 accepted, `flush`=1 -> 0xD002 never appears and `out_valid`=0 next cycle.
- Counter wrap (`IF_ID_PERF_EN`, `CNT_W`=4): keep the stage empty for 17 cycles -> `bubble_cnt`=1.
